vga_sync_module: RTL



---
 rtl/vga_pkg.sv | 49 ++++
 rtl/vga_axis_counter.sv | 61 ++++++
 rtl/vga_sync_module.sv | 90 +++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA raster timing constants and helpers for the sync generator and its axis counters.
package vga_pkg;

    // 640x480 @ 60 Hz timing, the default board setting
    localparam int H_SYNC_640   = 96;
    localparam int H_BACK_640   = 48;
    localparam int H_ACTIVE_640 = 640;
    localparam int H_FRONT_640  = 16;
    localparam int V_SYNC_640   = 2;
    localparam int V_BACK_640   = 33;
    localparam int V_ACTIVE_640 = 480;
    localparam int V_FRONT_640  = 10;

    localparam int H_TOTAL_640     = H_SYNC_640 + H_BACK_640 + H_ACTIVE_640 + H_FRONT_640;
    localparam int V_TOTAL_640     = V_SYNC_640 + V_BACK_640 + V_ACTIVE_640 + V_FRONT_640;
    localparam int H_ACT_START_640 = H_SYNC_640 + H_BACK_640;
    localparam int H_ACT_END_640   = H_ACT_START_640 + H_ACTIVE_640;
    localparam int V_ACT_START_640 = V_SYNC_640 + V_BACK_640;
    localparam int V_ACT_END_640   = V_ACT_START_640 + V_ACTIVE_640;

    // 800x600 @ 60 Hz timing for the later boards with a faster pixel clock
    localparam int H_SYNC_800   = 128;
    localparam int H_BACK_800   = 88;
    localparam int H_ACTIVE_800 = 800;
    localparam int H_FRONT_800  = 40;
    localparam int V_SYNC_800   = 4;
    localparam int V_BACK_800   = 23;
    localparam int V_ACTIVE_800 = 600;
    localparam int V_FRONT_800  = 1;

    localparam int H_TOTAL_800     = H_SYNC_800 + H_BACK_800 + H_ACTIVE_800 + H_FRONT_800;
    localparam int V_TOTAL_800     = V_SYNC_800 + V_BACK_800 + V_ACTIVE_800 + V_FRONT_800;
    localparam int H_ACT_START_800 = H_SYNC_800 + H_BACK_800;
    localparam int H_ACT_END_800   = H_ACT_START_800 + H_ACTIVE_800;
    localparam int V_ACT_START_800 = V_SYNC_800 + V_BACK_800;
    localparam int V_ACT_END_800   = V_ACT_START_800 + V_ACTIVE_800;

    // Sync strobes are active-low on the standard VGA modes
    localparam bit SYNC_POL_DEFAULT = 1'b0;
    localparam int ADDR_W_DEFAULT   = 12;

    // A timing set is usable only if every segment exists and the visible span fits the address width
    function automatic bit segments_valid(input int sync, input int back, input int active,
                                          input int front, input int addr_w);
        return (sync > 0) && (back > 0) && (active > 0) && (front > 0)
            && (longint'(active) <= (longint'(1) << addr_w));
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster dimension: counts sync/back/active/front segments and decodes the upcoming count.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int SYNC   = H_SYNC_640,
    parameter int BACK   = H_BACK_640,
    parameter int ACTIVE = H_ACTIVE_640,
    parameter int FRONT  = H_FRONT_640,
    parameter int ADDR_W = ADDR_W_DEFAULT
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              wrap,
    output logic              next_in_sync,
    output logic              next_in_active,
    output logic [ADDR_W-1:0] next_offset
);

    localparam int TOTAL = SYNC + BACK + ACTIVE + FRONT;
    localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_END  = CNT_W'(SYNC);
    localparam logic [CNT_W-1:0] ACT_START = CNT_W'(SYNC + BACK);
    localparam logic [CNT_W-1:0] ACT_END   = CNT_W'(SYNC + BACK + ACTIVE);

    localparam bit CFG_OK = segments_valid(SYNC, BACK, ACTIVE, FRONT, ADDR_W);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] offset_full;

    // Work out where the counter lands on the next edge so outputs can be registered with no lag
    always_comb begin
        cnt_next = cnt;
        if (en) begin
            cnt_next = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign wrap           = en && (cnt == LAST);
    assign next_in_sync   = (cnt_next < SYNC_END);
    assign next_in_active = (cnt_next >= ACT_START) && (cnt_next < ACT_END);
    assign offset_full    = cnt_next - ACT_START;
    assign next_offset    = next_in_active ? ADDR_W'(offset_full) : '0;

    // Position register, parked at zero while reset is held
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    // An impossible timing set is reported as soon as the clock runs
    cfg_check: assert property (@(posedge clk) CFG_OK)
        else $error("vga_axis_counter: zero-length segment or ACTIVE exceeds 2**ADDR_W");

endmodule

// File: rtl/vga_sync_module.sv
// VGA raster timing generator: sync strobes, active-video qualifier, pixel coordinates, frame pulse.
module vga_sync_module
    import vga_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_640,
    parameter int H_BACK   = H_BACK_640,
    parameter int H_ACTIVE = H_ACTIVE_640,
    parameter int H_FRONT  = H_FRONT_640,
    parameter int V_SYNC   = V_SYNC_640,
    parameter int V_BACK   = V_BACK_640,
    parameter int V_ACTIVE = V_ACTIVE_640,
    parameter int V_FRONT  = V_FRONT_640,
    parameter bit SYNC_POL = SYNC_POL_DEFAULT,
    parameter int ADDR_W   = ADDR_W_DEFAULT
)(
    input  logic              vga_clk,
    input  logic              rst,
    output logic              HSYNC_Sig,
    output logic              VSYNC_Sig,
    output logic              Ready_Sig,
    output logic [ADDR_W-1:0] Column_Addr_Sig,
    output logic [ADDR_W-1:0] Row_Addr_Sig,
    output logic              Frame_Start_Sig
);

    logic              h_wrap;
    logic              h_next_sync;
    logic              h_next_active;
    logic [ADDR_W-1:0] h_next_offset;
    logic              v_wrap;
    logic              v_next_sync;
    logic              v_next_active;
    logic [ADDR_W-1:0] v_next_offset;
    logic              next_ready;

    vga_axis_counter #(
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .ADDR_W (ADDR_W)
    ) u_h_axis (
        .clk            (vga_clk),
        .rst            (rst),
        .en             (1'b1),
        .wrap           (h_wrap),
        .next_in_sync   (h_next_sync),
        .next_in_active (h_next_active),
        .next_offset    (h_next_offset)
    );

    // The vertical axis steps once per line, on the horizontal wrap
    vga_axis_counter #(
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .ADDR_W (ADDR_W)
    ) u_v_axis (
        .clk            (vga_clk),
        .rst            (rst),
        .en             (h_wrap),
        .wrap           (v_wrap),
        .next_in_sync   (v_next_sync),
        .next_in_active (v_next_active),
        .next_offset    (v_next_offset)
    );

    assign next_ready = h_next_active && v_next_active;

    // Register every output from the next-count decode so it lines up with the counters
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            HSYNC_Sig       <= SYNC_POL;
            VSYNC_Sig       <= SYNC_POL;
            Ready_Sig       <= 1'b0;
            Column_Addr_Sig <= '0;
            Row_Addr_Sig    <= '0;
            Frame_Start_Sig <= 1'b0;
        end else begin
            HSYNC_Sig       <= h_next_sync ? SYNC_POL : ~SYNC_POL;
            VSYNC_Sig       <= v_next_sync ? SYNC_POL : ~SYNC_POL;
            Ready_Sig       <= next_ready;
            Column_Addr_Sig <= next_ready ? h_next_offset : '0;
            Row_Addr_Sig    <= next_ready ? v_next_offset : '0;
            Frame_Start_Sig <= h_wrap && v_wrap;
        end
    end

endmodule
